// File: rtl/cond_unit.sv
// cond_unit: conditional-execution unit for the ASIP datapath.
// Holds the NZCV flag register, evaluates condition codes against it,
// gates decoder enables, commits ALU flags on executed instructions and
// keeps saturating execute/skip profiling counters.
module cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [3:0]  cond_i,
  input  logic [1:0]  flag_w_i,
  input  logic [3:0]  alu_flags_i,
  input  logic        reg_w_i,
  input  logic        mem_w_i,
  input  logic        pc_s_i,
  input  logic        cnt_clr_i,
  output logic        valid_o,
  output logic        cond_ex_o,
  output logic        reg_w_o,
  output logic        mem_w_o,
  output logic        pc_s_o,
  output logic [3:0]  flags_o,
  output logic [15:0] exec_cnt_o,
  output logic [15:0] skip_cnt_o
);

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000,
    CC_NE = 4'b0001,
    CC_CS = 4'b0010,
    CC_CC = 4'b0011,
    CC_MI = 4'b0100,
    CC_PL = 4'b0101,
    CC_VS = 4'b0110,
    CC_VC = 4'b0111,
    CC_HI = 4'b1000,
    CC_LS = 4'b1001,
    CC_GE = 4'b1010,
    CC_LT = 4'b1011,
    CC_GT = 4'b1100,
    CC_LE = 4'b1101,
    CC_AL = 4'b1110,
    CC_NV = 4'b1111
  } cond_e;

  logic [3:0]  flags_q, flags_d;
  logic        valid_q, valid_d;
  logic        cond_ex_q, cond_ex_d;
  logic        reg_w_q, reg_w_d;
  logic        mem_w_q, mem_w_d;
  logic        pc_s_q, pc_s_d;
  logic [15:0] exec_cnt_q, exec_cnt_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;

  logic  accept;
  logic  cond_ex;
  logic  execute;
  logic  flag_n, flag_z, flag_c, flag_v;
  cond_e cond;

  assign accept  = valid_i & ~flush_i;
  assign execute = accept & cond_ex;
  assign cond    = cond_e'(cond_i);

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition evaluation against the registered (pre-update) flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      CC_EQ:   cond_ex = flag_z;
      CC_NE:   cond_ex = ~flag_z;
      CC_CS:   cond_ex = flag_c;
      CC_CC:   cond_ex = ~flag_c;
      CC_MI:   cond_ex = flag_n;
      CC_PL:   cond_ex = ~flag_n;
      CC_VS:   cond_ex = flag_v;
      CC_VC:   cond_ex = ~flag_v;
      CC_HI:   cond_ex = flag_c & ~flag_z;
      CC_LS:   cond_ex = ~flag_c | flag_z;
      CC_GE:   cond_ex = (flag_n == flag_v);
      CC_LT:   cond_ex = (flag_n != flag_v);
      CC_GT:   cond_ex = ~flag_z & (flag_n == flag_v);
      CC_LE:   cond_ex = flag_z | (flag_n != flag_v);
      CC_AL:   cond_ex = 1'b1;
      CC_NV:   cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag commit: N,Z and C,V pairs load independently, only when executed.
  always_comb begin
    flags_d = flags_q;
    if (execute) begin
      if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  // Output stage next values: everything gated by accept and condition.
  always_comb begin
    valid_d   = accept;
    cond_ex_d = execute;
    reg_w_d   = execute & reg_w_i;
    mem_w_d   = execute & mem_w_i;
    pc_s_d    = execute & pc_s_i;
  end

  // Profiling counters: clear wins over increment, both saturate at all-ones.
  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (cnt_clr_i) begin
      exec_cnt_d = '0;
      skip_cnt_d = '0;
    end else if (accept) begin
      if (cond_ex) begin
        if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + 16'd1;
      end else begin
        if (skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + 16'd1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q    <= '0;
      valid_q    <= 1'b0;
      cond_ex_q  <= 1'b0;
      reg_w_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      pc_s_q     <= 1'b0;
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      cond_ex_q  <= cond_ex_d;
      reg_w_q    <= reg_w_d;
      mem_w_q    <= mem_w_d;
      pc_s_q     <= pc_s_d;
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign valid_o    = valid_q;
  assign cond_ex_o  = cond_ex_q;
  assign reg_w_o    = reg_w_q;
  assign mem_w_o    = mem_w_q;
  assign pc_s_o     = pc_s_q;
  assign flags_o    = flags_q;
  assign exec_cnt_o = exec_cnt_q;
  assign skip_cnt_o = skip_cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed issues push hand-computed
// expected output snapshots; a negedge monitor pops and compares them.
module tb_cond_unit;

  logic        clk;
  logic        reset;
  logic        valid_i, flush_i, reg_w_i, mem_w_i, pc_s_i, cnt_clr_i;
  logic [3:0]  cond_i, alu_flags_i;
  logic [1:0]  flag_w_i;
  logic        valid_o, cond_ex_o, reg_w_o, mem_w_o, pc_s_o;
  logic [3:0]  flags_o;
  logic [15:0] exec_cnt_o, skip_cnt_o;

  cond_unit dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .cond_i     (cond_i),
    .flag_w_i   (flag_w_i),
    .alu_flags_i(alu_flags_i),
    .reg_w_i    (reg_w_i),
    .mem_w_i    (mem_w_i),
    .pc_s_i     (pc_s_i),
    .cnt_clr_i  (cnt_clr_i),
    .valid_o    (valid_o),
    .cond_ex_o  (cond_ex_o),
    .reg_w_o    (reg_w_o),
    .mem_w_o    (mem_w_o),
    .pc_s_o     (pc_s_o),
    .flags_o    (flags_o),
    .exec_cnt_o (exec_cnt_o),
    .skip_cnt_o (skip_cnt_o)
  );

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [40:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [40:0] snap();
    return {valid_o, cond_ex_o, reg_w_o, mem_w_o, pc_s_o, flags_o, exec_cnt_o, skip_cnt_o};
  endfunction

  task automatic chk(input string name, input logic [40:0] got, input logic [40:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got v/c/rw/mw/ps=%b flags=%b exec=%h skip=%h, expected v/c/rw/mw/ps=%b flags=%b exec=%h skip=%h",
               name, got[40:36], got[35:32], got[31:16], got[15:0],
               exp[40:36], exp[35:32], exp[31:16], exp[15:0]);
    end
  endtask

  // Monitor: compare the entry due at this cycle's sample point.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].cyc == cyc) begin
        chk(sb[0].name, snap(), sb[0].exp);
        void'(sb.pop_front());
      end else if (sb[0].cyc < cyc) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL %s: expected entry missed at cycle %0d, now %0d", sb[0].name, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic f, input logic [3:0] cond, input logic [1:0] fw,
                       input logic [3:0] alu, input logic rw, input logic mw, input logic ps,
                       input logic clr);
    valid_i = v; flush_i = f; cond_i = cond; flag_w_i = fw; alu_flags_i = alu;
    reg_w_i = rw; mem_w_i = mw; pc_s_i = ps; cnt_clr_i = clr;
  endtask

  // Drive one instruction for one cycle; expected state one cycle later.
  task automatic issue(input string name, input logic v, input logic f, input logic [3:0] cond,
                       input logic [1:0] fw, input logic [3:0] alu, input logic rw, input logic mw,
                       input logic ps, input logic clr, input logic [4:0] eo, input logic [3:0] ef,
                       input logic [15:0] ee, input logic [15:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v, f, cond, fw, alu, rw, mw, ps, clr);
    e.cyc  = cyc + 1;
    e.name = name;
    e.exp  = {eo, ef, ee, es};
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
    #1;
    chk("reset_state", snap(), 41'd0);
    #11 reset = 1'b0;

    //     name            v f cond   fw     alu     rw mw ps clr  v c rw mw ps  flags   exec     skip
    issue("al_first",      1,0,4'hE,2'b11,4'b0100, 1,0,0,0, 5'b11100,4'b0100,16'd1, 16'd0);
    issue("eq_pass",       1,0,4'h0,2'b00,4'b0000, 0,1,0,0, 5'b11010,4'b0100,16'd2, 16'd0);
    issue("ne_skip",       1,0,4'h1,2'b00,4'b0000, 0,1,0,0, 5'b10000,4'b0100,16'd2, 16'd1);
    issue("clr_flags",     1,0,4'hE,2'b11,4'b0000, 0,0,0,0, 5'b11000,4'b0000,16'd3, 16'd1);
    issue("al_cv_only",    1,0,4'hE,2'b01,4'b1111, 0,0,0,0, 5'b11000,4'b0011,16'd4, 16'd1);
    issue("hi_pass",       1,0,4'h8,2'b00,4'b0000, 0,0,1,0, 5'b11001,4'b0011,16'd5, 16'd1);
    issue("zero_flags",    1,0,4'hE,2'b11,4'b0000, 0,0,0,0, 5'b11000,4'b0000,16'd6, 16'd1);
    issue("skip_no_flags", 1,0,4'h0,2'b11,4'b1000, 1,0,0,0, 5'b10000,4'b0000,16'd6, 16'd2);
    issue("flush",         1,1,4'hE,2'b11,4'b1111, 1,0,0,0, 5'b00000,4'b0000,16'd6, 16'd2);
    issue("nv_skip",       1,0,4'hF,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b0000,16'd6, 16'd3);
    issue("idle",          0,0,4'hE,2'b11,4'b1111, 1,1,1,0, 5'b00000,4'b0000,16'd6, 16'd3);
    issue("set_z",         1,0,4'hE,2'b11,4'b0100, 0,0,0,0, 5'b11000,4'b0100,16'd7, 16'd3);
    issue("eq_old_flags",  1,0,4'h0,2'b11,4'b0000, 1,0,0,0, 5'b11100,4'b0000,16'd8, 16'd3);
    issue("eq_new_flags",  1,0,4'h0,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b0000,16'd8, 16'd4);
    issue("set_nv",        1,0,4'hE,2'b11,4'b1001, 0,0,0,0, 5'b11000,4'b1001,16'd9, 16'd4);
    issue("ge_pass",       1,0,4'hA,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b1001,16'd10,16'd4);
    issue("lt_skip",       1,0,4'hB,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b1001,16'd10,16'd5);
    issue("gt_pass",       1,0,4'hC,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b1001,16'd11,16'd5);
    issue("le_skip",       1,0,4'hD,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b1001,16'd11,16'd6);
    issue("mi_pass",       1,0,4'h4,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b1001,16'd12,16'd6);
    issue("pl_skip",       1,0,4'h5,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b1001,16'd12,16'd7);
    issue("vs_pass",       1,0,4'h6,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b1001,16'd13,16'd7);
    issue("vc_skip",       1,0,4'h7,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b1001,16'd13,16'd8);
    issue("cs_skip",       1,0,4'h2,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b1001,16'd13,16'd9);
    issue("cc_pass",       1,0,4'h3,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b1001,16'd14,16'd9);
    issue("ls_pass",       1,0,4'h9,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b1001,16'd15,16'd9);
    issue("hi_skip",       1,0,4'h8,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b1001,16'd15,16'd10);
    issue("clr_accept",    1,0,4'hE,2'b00,4'b0000, 1,0,0,1, 5'b11100,4'b1001,16'd0, 16'd0);

    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      #1;
      drive(1, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0);
    end
    issue("exec_saturate", 1,0,4'hE,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b1001,16'hFFFF,16'd0);
    issue("clr_at_sat",    1,0,4'hE,2'b00,4'b0000, 0,0,0,1, 5'b11000,4'b1001,16'd0, 16'd0);

    @(posedge clk);
    #1;
    drive(1, 0, 4'hE, 2'b00, 4'h0, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_reset", snap(), {5'b11100, 4'b1001, 16'd1, 16'd0});
    #1 reset = 1'b1;
    #1;
    chk("async_reset", snap(), 41'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    drive(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);

    issue("eq_after_rst",  1,0,4'h0,2'b00,4'b0000, 1,0,0,0, 5'b10000,4'b0000,16'd0, 16'd1);
    issue("ne_after_rst",  1,0,4'h1,2'b00,4'b0000, 1,0,0,0, 5'b11100,4'b0000,16'd1, 16'd1);
    issue("final_idle",    0,0,4'h0,2'b00,4'b0000, 0,0,0,0, 5'b00000,4'b0000,16'd1, 16'd1);

    repeat (3) @(posedge clk);
    #2;
    tests = tests + 1;
    if (sb.size() != 0) begin
      fails = fails + 1;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
